// File: rtl/mic_frame_aligner.sv
// Aligns three drifting mic sample streams into three-channel frames on a valid/ready handshake.
// Optional MIC_FRAME_ALIGNER_STATS_EN adds saturating drop/resync counters.
module mic_frame_aligner #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 8,
   parameter int SKEW_LIMIT = 3
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [2:0]       valid_in,
   input  logic [WIDTH-1:0] sample_1_in,
   input  logic [WIDTH-1:0] sample_2_in,
   input  logic [WIDTH-1:0] sample_3_in,
   input  logic             frame_ready_in,
   input  logic             clear_in,
   output logic             frame_valid_out,
   output logic [WIDTH-1:0] frame_1_out,
   output logic [WIDTH-1:0] frame_2_out,
   output logic [WIDTH-1:0] frame_3_out,
   output logic [2:0]       overflow_out,
`ifdef MIC_FRAME_ALIGNER_STATS_EN
   output logic [15:0]      drop_count_out,
   output logic [15:0]      resync_count_out,
`endif
   output logic             resync_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] mem [3][DEPTH];
   logic [PTR_W-1:0]        wr_ptr [3];
   logic [PTR_W-1:0]        rd_ptr [3];
   logic [CNT_W-1:0]        cnt [3];
   logic signed [WIDTH-1:0] sample_p0 [3];
   logic [2:0]              full, nonempty, wr_en, drop;
   logic                    run, flush, pop, slot_free, skew_err;
   logic [CNT_W-1:0]        cnt_max, cnt_min;
   logic                    vld_p1;
   logic signed [WIDTH-1:0] frame_p1 [3];

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, a} + {15'b0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   function automatic logic [1:0] ones3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

   assign sample_p0[0] = sample_1_in;
   assign sample_p0[1] = sample_2_in;
   assign sample_p0[2] = sample_3_in;

   assign run       = (state_q == RUN);
   assign slot_free = !vld_p1 || frame_ready_in;
   assign pop       = run && (&nonempty) && slot_free;

   always_comb begin
      full     = '0;
      nonempty = '0;
      wr_en    = '0;
      drop     = '0;
      for (int i = 0; i < 3; i++) begin
         full[i]     = (cnt[i] == CNT_W'(DEPTH));
         nonempty[i] = (cnt[i] != '0);
         // A full FIFO still accepts a write when its head leaves in the same cycle.
         wr_en[i]    = run && valid_in[i] && (!full[i] || pop);
         drop[i]     = run && valid_in[i] && full[i] && !pop;
      end
   end

   always_comb begin
      cnt_max = cnt[0];
      cnt_min = cnt[0];
      for (int i = 1; i < 3; i++) begin
         if (cnt[i] > cnt_max) cnt_max = cnt[i];
         if (cnt[i] < cnt_min) cnt_min = cnt[i];
      end
      skew_err = (cnt_max - cnt_min) > CNT_W'(SKEW_LIMIT);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= RUN;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (skew_err || (|drop)) state_d = FLUSH;
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      flush      = (state_q == FLUSH);
      resync_out = flush;
   end

   // Stage p0: per-channel FIFO storage and bookkeeping
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < 3; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < 3; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            cnt[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop)      rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            case ({wr_en[i], pop})
               2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
               2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk_in) begin
      for (int i = 0; i < 3; i++) begin
         if (wr_en[i]) mem[i][wr_ptr[i]] <= sample_p0[i];
      end
   end

   // Stage p1: single-entry output slot
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         vld_p1 <= 1'b0;
         for (int i = 0; i < 3; i++) frame_p1[i] <= '0;
      end else if (pop) begin
         vld_p1 <= 1'b1;
         for (int i = 0; i < 3; i++) frame_p1[i] <= mem[i][rd_ptr[i]];
      end else if (frame_ready_in) begin
         vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) overflow_out <= '0;
      else         overflow_out <= (overflow_out & ~{3{clear_in}}) | drop;
   end

`ifdef MIC_FRAME_ALIGNER_STATS_EN
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         drop_count_out   <= '0;
         resync_count_out <= '0;
      end else if (clear_in) begin
         drop_count_out   <= '0;
         resync_count_out <= '0;
      end else begin
         drop_count_out   <= sat_add16(drop_count_out, ones3(drop));
         resync_count_out <= sat_add16(resync_count_out, {1'b0, flush});
      end
   end
`endif

   assign frame_valid_out = vld_p1;
   assign frame_1_out     = frame_p1[0];
   assign frame_2_out     = frame_p1[1];
   assign frame_3_out     = frame_p1[2];

endmodule
